// File: rtl/ysyx_25040101_ifu.sv
// Instruction fetch unit: owns the fetch PC, issues in-order imem requests under a credit limit,
// buffers responses in a small FIFO and hands {inst, pc, fault} to decode; accepts redirects.
// Optional performance counters are built when YSYX_25040101_IFU_PERF_EN is defined.
module ysyx_25040101_ifu #(
    parameter logic [31:0] RESET_PC   = 32'h8000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        imem_rsp_err,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o,
    output logic        inst_fault_o,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
`ifdef YSYX_25040101_IFU_PERF_EN
    ,
    output logic [31:0] perf_fetch_o,
    output logic [31:0] perf_drop_o,
    output logic [31:0] perf_stall_o
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    typedef enum logic [1:0] {
        S_BOOT,
        S_RUN,
        S_DRAIN,
        S_HALT
    } state_t;

    state_t           state_q, state_d;
    logic             halt_pend_q, halt_pend_d;
    logic [31:0]      fetch_pc_q;
    logic [31:0]      rsp_pc_q;
    logic [CNT_W-1:0] outstanding_q;
    logic [CNT_W-1:0] drop_q, drop_nxt;
    logic [CNT_W-1:0] count_q;
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;

    logic [31:0]      buf_inst  [FIFO_DEPTH];
    logic [31:0]      buf_pc    [FIFO_DEPTH];
    logic             buf_fault [FIFO_DEPTH];

    logic             redir;
    logic             misalign;
    logic             accept;
    logic             rsp_drop;
    logic             rsp_push;
    logic             pop;
    logic             credit_ok;
    logic [CNT_W-1:0] rsp_dec;
    logic [CNT_W-1:0] remain;
    logic [CNT_W:0]   inflight;

    logic             wr_en;
    logic [PTR_W-1:0] wr_idx;
    logic [31:0]      wr_inst;
    logic [31:0]      wr_pc;
    logic             wr_fault;

    assign redir     = redirect_valid && (state_q != S_BOOT);
    assign misalign  = redir && (redirect_pc[1:0] != 2'b00);
    assign rsp_dec   = imem_rsp_valid ? CNT_ONE : '0;
    // Requests still in flight once this cycle's response has retired; these must be dropped.
    assign remain    = outstanding_q - rsp_dec;
    assign inflight  = {1'b0, outstanding_q} + {1'b0, count_q};
    assign credit_ok = inflight < {1'b0, DEPTH_C};

    assign imem_req_valid = (state_q == S_RUN) && credit_ok && !redirect_valid;
    assign imem_req_addr  = fetch_pc_q;
    assign accept         = imem_req_valid && imem_req_ready;
    assign rsp_drop       = imem_rsp_valid && (redir || (drop_q != '0));
    assign rsp_push       = imem_rsp_valid && !rsp_drop;
    assign pop            = inst_valid && inst_ready && !redir;

    always_comb begin
        drop_nxt = drop_q;
        if (redir) begin
            drop_nxt = remain;
        end else if (imem_rsp_valid && (drop_q != '0)) begin
            drop_nxt = drop_q - CNT_ONE;
        end
    end

    always_comb begin
        state_d     = state_q;
        halt_pend_d = halt_pend_q;
        case (state_q)
            S_BOOT: begin
                state_d = S_RUN;
            end
            default: begin
                if (redir) begin
                    if (remain != '0) begin
                        state_d     = S_DRAIN;
                        halt_pend_d = misalign;
                    end else begin
                        state_d     = misalign ? S_HALT : S_RUN;
                        halt_pend_d = 1'b0;
                    end
                end else if ((state_q == S_DRAIN) && (drop_nxt == '0)) begin
                    state_d     = halt_pend_q ? S_HALT : S_RUN;
                    halt_pend_d = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_BOOT;
            halt_pend_q   <= 1'b0;
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
        end else begin
            state_q       <= state_d;
            halt_pend_q   <= halt_pend_d;
            drop_q        <= drop_nxt;
            outstanding_q <= outstanding_q + (accept ? CNT_ONE : '0) - rsp_dec;
            if (redir) begin
                fetch_pc_q <= redirect_pc;
                rsp_pc_q   <= redirect_pc;
            end else begin
                if (accept) begin
                    fetch_pc_q <= fetch_pc_q + 32'd4;
                end
                // rsp_pc tracks the PC of the oldest surviving request; dropped responses never advance it.
                if (rsp_push) begin
                    rsp_pc_q <= rsp_pc_q + 32'd4;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (redir) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= misalign ? PTR_ONE : '0;
            count_q  <= misalign ? CNT_ONE : '0;
        end else begin
            if (rsp_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            count_q <= count_q + (rsp_push ? CNT_ONE : '0) - (pop ? CNT_ONE : '0);
        end
    end

    // A misaligned redirect replaces the flushed buffer with a single fault marker in slot 0.
    always_comb begin
        wr_en    = rsp_push;
        wr_idx   = wr_ptr_q;
        wr_inst  = imem_rsp_data;
        wr_pc    = rsp_pc_q;
        wr_fault = imem_rsp_err;
        if (misalign) begin
            wr_en    = 1'b1;
            wr_idx   = '0;
            wr_inst  = '0;
            wr_pc    = redirect_pc;
            wr_fault = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            buf_inst[wr_idx]  <= wr_inst;
            buf_pc[wr_idx]    <= wr_pc;
            buf_fault[wr_idx] <= wr_fault;
        end
    end

    assign inst_valid   = (count_q != '0);
    assign inst_o       = inst_valid ? buf_inst[rd_ptr_q]  : '0;
    assign inst_pc_o    = inst_valid ? buf_pc[rd_ptr_q]    : '0;
    assign inst_fault_o = inst_valid ? buf_fault[rd_ptr_q] : 1'b0;

`ifdef YSYX_25040101_IFU_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetch_o <= '0;
            perf_drop_o  <= '0;
            perf_stall_o <= '0;
        end else begin
            if (accept) begin
                perf_fetch_o <= perf_fetch_o + 32'd1;
            end
            if (rsp_drop) begin
                perf_drop_o <= perf_drop_o + 32'd1;
            end
            if (inst_valid && !inst_ready) begin
                perf_stall_o <= perf_stall_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ysyx_25040101_ifu.sv
// Self-checking bench for ysyx_25040101_ifu: randomized memory/decode/redirect traffic checked against
// a program-order fetch model, plus directed boot, stall, redirect, fault, wrap and async-reset steps.
module tb_ysyx_25040101_ifu;

    localparam logic [31:0] RST_PC = 32'h8000_0000;
    localparam int          DEPTH  = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        inst_fault_o;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
`ifdef YSYX_25040101_IFU_PERF_EN
    logic [31:0] perf_fetch_o;
    logic [31:0] perf_drop_o;
    logic [31:0] perf_stall_o;
`endif

    ysyx_25040101_ifu #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .imem_rsp_err   (imem_rsp_err),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_o         (inst_o),
        .inst_pc_o      (inst_pc_o),
        .inst_fault_o   (inst_fault_o),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
`ifdef YSYX_25040101_IFU_PERF_EN
        ,
        .perf_fetch_o   (perf_fetch_o),
        .perf_drop_o    (perf_drop_o),
        .perf_stall_o   (perf_stall_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
    } req_t;

    req_t        mq[$];          // requests accepted by memory, in order
    int          cyc;
    int          buf_cnt;        // entries decode can see
    int          total;
    int          bad;
    int          pops;
    bit          boot;
    bit          halted;
    bit          fault_pend;
    logic [31:0] exp_req_pc;     // next address the IFU must request
    logic [31:0] s_pc;           // next PC decode must receive
    logic [31:0] fpc;
    int          p_ready;
    int          p_irdy;
    int          lat_min;
    int          lat_max;
    bit          drv_redir;
    logic [31:0] drv_rpc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic is_err(input logic [31:0] a);
        return (a == 32'h8000_0008) || (a[7:2] == 6'h2B);
    endfunction

    function automatic int fresh_cnt();
        int n = 0;
        foreach (mq[i]) if (!mq[i].stale) n++;
        return n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        buf_cnt    = 0;
        exp_req_pc = RST_PC;
        s_pc       = RST_PC;
        fault_pend = 1'b0;
        halted     = 1'b0;
        boot       = 1'b1;
        drv_redir  = 1'b0;
    endtask

    // One clock cycle: starts and ends just after a falling edge.
    task automatic step();
        req_t cur;
        bit   rsp_now;
        bit   cur_stale;
        bit   draining;
        bit   acc;
        bit   pop;
        bit   mis;
        int   outst;
        int   lat;
        rsp_now   = 1'b0;
        cur_stale = 1'b0;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            cur            = mq.pop_front();
            rsp_now        = 1'b1;
            cur_stale      = cur.stale;
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(cur.addr);
            imem_rsp_err   = is_err(cur.addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
            imem_rsp_err   = 1'($urandom_range(1));
        end
        imem_req_ready = (int'($urandom_range(99)) < p_ready);
        inst_ready     = (int'($urandom_range(99)) < p_irdy);
        redirect_valid = drv_redir && !boot;
        redirect_pc    = drv_redir ? drv_rpc : $urandom;
        drv_redir      = 1'b0;
        #1;
        outst    = mq.size() + (rsp_now ? 1 : 0);
        draining = cur_stale;
        foreach (mq[i]) if (mq[i].stale) draining = 1'b1;
        chk("inst_valid", 32'(inst_valid), 32'(buf_cnt != 0));
        chk("req_valid", 32'(imem_req_valid),
            32'(!boot && !halted && !draining && !redirect_valid && (outst + buf_cnt < DEPTH)));

        acc = imem_req_valid && imem_req_ready;
        if (acc) begin
            chk("req_addr", imem_req_addr, exp_req_pc);
            lat = int'($urandom_range(lat_max, lat_min));
            mq.push_back('{exp_req_pc, cyc + lat, 1'b0});
            exp_req_pc = exp_req_pc + 32'd4;
        end

        pop = inst_valid && inst_ready && !redirect_valid;
        if (pop && buf_cnt > 0) begin
            if (fault_pend) begin
                chk("fault_inst", inst_o, 32'h0);
                chk("fault_pc", inst_pc_o, fpc);
                chk("fault_flag", 32'(inst_fault_o), 32'd1);
                fault_pend = 1'b0;
            end else begin
                chk("head_pc", inst_pc_o, s_pc);
                chk("head_inst", inst_o, mem_word(s_pc));
                chk("head_fault", 32'(inst_fault_o), 32'(is_err(s_pc)));
                s_pc = s_pc + 32'd4;
            end
            buf_cnt--;
            pops++;
        end

        if (rsp_now && !cur_stale && !redirect_valid) begin
            chk("push_room", 32'(buf_cnt < DEPTH), 32'd1);
            buf_cnt++;
        end

        if (redirect_valid) begin
            mis = (redirect_pc[1:0] != 2'b00);
            foreach (mq[i]) mq[i].stale = 1'b1;
            buf_cnt    = mis ? 1 : 0;
            exp_req_pc = redirect_pc;
            s_pc       = redirect_pc;
            fpc        = redirect_pc;
            fault_pend = mis;
            halted     = mis;
        end

        @(posedge clk);
        cyc++;
        boot = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0; bad = 0; cyc = 0; pops = 0;
        rst = 1'b1;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0; imem_rsp_err = 1'b0;
        inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        p_ready = 100; p_irdy = 100; lat_min = 1; lat_max = 1;
        fpc = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_inst", inst_o, 32'h0);
        chk("rst_pc", inst_pc_o, 32'h0);
        chk("rst_fault", 32'(inst_fault_o), 32'd0);
        rst = 1'b0;

        // Boot and straight-line fetch with 1-cycle memory; the 3rd fetch carries an access fault.
        pops = 0;
        repeat (30) step();
        chk("t1_progress", 32'(pops >= 10), 32'd1);

        // Decode stalls: credits run out and nothing is lost once it resumes.
        p_irdy = 0;
        repeat (10) step();
        chk("t2_req_blocked", 32'(imem_req_valid), 32'd0);
        chk("t2_buffered", 32'(buf_cnt), 32'(DEPTH));
        p_irdy = 100;
        repeat (20) step();

        // Redirect with two requests in flight.
        lat_min = 4; lat_max = 4;
        for (int k = 0; k < 40 && fresh_cnt() < 2; k++) step();
        chk("t3_two_inflight", 32'(fresh_cnt()), 32'd2);
        drv_redir = 1'b1; drv_rpc = 32'h8000_1000;
        pops = 0;
        repeat (30) step();
        chk("t3_progress", 32'(pops > 0), 32'd1);

        // Misaligned redirect: single fault entry, then halt until redirected.
        lat_min = 1; lat_max = 3;
        drv_redir = 1'b1; drv_rpc = 32'h8000_0002;
        repeat (20) step();
        chk("t4_fault_popped", 32'(fault_pend), 32'd0);
        drv_redir = 1'b1; drv_rpc = RST_PC;
        pops = 0;
        repeat (20) step();
        chk("t4_resumed", 32'(pops > 0), 32'd1);

        // Fetch PC wraps past the top of the address space.
        drv_redir = 1'b1; drv_rpc = 32'hFFFF_FFF8;
        repeat (20) step();

        // Randomized traffic with occasional redirects, some misaligned.
        p_ready = 70; p_irdy = 70; lat_min = 1; lat_max = 5;
        for (int n = 0; n < 1500; n++) begin
            if (!boot && int'($urandom_range(99)) < (halted ? 15 : 3)) begin
                drv_redir = 1'b1;
                drv_rpc   = 32'h8000_0000 + ($urandom_range(255) << 2);
                if ($urandom_range(9) == 0) drv_rpc[1:0] = 2'($urandom_range(3, 1));
            end
            step();
        end

        // Asynchronous reset while draining a redirect.
        p_ready = 100; p_irdy = 100; lat_min = 6; lat_max = 6;
        drv_redir = 1'b1; drv_rpc = RST_PC + 32'h40;
        step();
        for (int k = 0; k < 40 && fresh_cnt() < 2; k++) step();
        chk("t6_inflight", 32'(fresh_cnt()), 32'd2);
        drv_redir = 1'b1; drv_rpc = 32'h8000_2000;
        step();
        #2;
        imem_rsp_valid = 1'b0;
        redirect_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("t6_req_valid", 32'(imem_req_valid), 32'd0);
        chk("t6_inst_valid", 32'(inst_valid), 32'd0);
        chk("t6_inst", inst_o, 32'h0);
        chk("t6_pc", inst_pc_o, 32'h0);
        chk("t6_fault", 32'(inst_fault_o), 32'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        lat_min = 1; lat_max = 2;
        pops = 0;
        repeat (25) step();
        chk("t6_refetch", 32'(pops > 0), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
